// File: rtl/touch_event_filter.sv
// touch_event_filter: touchpad sample conditioning.
// Clamp/offset X/Y, debounce pressure, 4-tap average.
module touch_event_filter #(
  parameter logic [11:0] Z_THRESH    = 12'h100,
  parameter logic [11:0] X_MIN       = 12'h090,
  parameter logic [11:0] X_MAX       = 12'h7D5,
  parameter logic [11:0] Y_MIN       = 12'h060,
  parameter logic [11:0] Y_MAX       = 12'h750,
  parameter int          SHIFT       = 2,
  parameter int          PRESS_CNT   = 3,
  parameter int          RELEASE_CNT = 2
) (
  input  logic        cclk,
  input  logic        rstb,
  input  logic        sample_valid,
  input  logic [11:0] raw_x,
  input  logic [11:0] raw_y,
  input  logic [11:0] raw_z,
  output logic [8:0]  x,
  output logic [8:0]  y,
  output logic        coord_valid,
  output logic        touching,
  output logic        press_pulse,
  output logic        release_pulse
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_PEND,
    TOUCHING,
    RELEASE_PEND
  } state_t;

  typedef struct packed {
    logic       hit;
    logic [8:0] ax;
    logic [8:0] ay;
  } s1_t;

  localparam logic [3:0] PCNT = PRESS_CNT[3:0];
  localparam logic [3:0] RCNT = RELEASE_CNT[3:0];

  logic [11:0] cx;
  logic [11:0] cy;
  logic [11:0] dx;
  logic [11:0] dy;
  s1_t         s1_d;
  s1_t         s1_q;
  logic        s1_valid;

  state_t      state_q;
  state_t      state_n;
  logic [3:0]  cnt_q;
  logic [3:0]  cnt_n;
  logic [3:0]  cnt_inc;
  logic [3:0][8:0] hx_q;
  logic [3:0][8:0] hx_n;
  logic [3:0][8:0] hy_q;
  logic [3:0][8:0] hy_n;
  logic [10:0] sum_x;
  logic [10:0] sum_y;
  logic [8:0]  x_n;
  logic [8:0]  y_n;
  logic        cv_n;
  logic        touch_n;
  logic        pp_n;
  logic        rp_n;

  // Clamp into the panel window, remove offset, scale down.
  always_comb begin
    cx = raw_x;
    cy = raw_y;
    if (raw_x < X_MIN) cx = X_MIN;
    else if (raw_x > X_MAX) cx = X_MAX;
    if (raw_y < Y_MIN) cy = Y_MIN;
    else if (raw_y > Y_MAX) cy = Y_MAX;
    dx = cx - X_MIN;
    dy = cy - Y_MIN;
    s1_d.ax  = 9'(dx >> SHIFT);
    s1_d.ay  = 9'(dy >> SHIFT);
    s1_d.hit = (raw_z >= Z_THRESH);
  end

  // Stage 1 register: capture the conditioned sample.
  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      s1_q     <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= sample_valid;
      if (sample_valid) s1_q <= s1_d;
    end
  end

  // Running sum of the new sample and the three newest slots.
  always_comb begin
    sum_x = {2'b00, s1_q.ax}
          + {2'b00, hx_q[0]}
          + {2'b00, hx_q[1]}
          + {2'b00, hx_q[2]};
    sum_y = {2'b00, s1_q.ay}
          + {2'b00, hy_q[0]}
          + {2'b00, hy_q[1]}
          + {2'b00, hy_q[2]};
  end

  assign cnt_inc = cnt_q + 4'd1;

  // Debounce FSM plus history/averaging next-state logic.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    hx_n    = hx_q;
    hy_n    = hy_q;
    x_n     = x;
    y_n     = y;
    cv_n    = 1'b0;
    touch_n = touching;
    pp_n    = 1'b0;
    rp_n    = 1'b0;
    if (s1_valid) begin
      unique case (state_q)
        IDLE: begin
          if (s1_q.hit) begin
            state_n = PRESS_PEND;
            cnt_n   = 4'd1;
          end
        end
        PRESS_PEND: begin
          if (!s1_q.hit) begin
            state_n = IDLE;
            cnt_n   = 4'd0;
          end else if (cnt_inc == PCNT) begin
            state_n = TOUCHING;
            cnt_n   = 4'd0;
            pp_n    = 1'b1;
            touch_n = 1'b1;
            hx_n    = {4{s1_q.ax}};
            hy_n    = {4{s1_q.ay}};
            x_n     = s1_q.ax;
            y_n     = s1_q.ay;
            cv_n    = 1'b1;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        TOUCHING: begin
          if (s1_q.hit) begin
            hx_n = {hx_q[2:0], s1_q.ax};
            hy_n = {hy_q[2:0], s1_q.ay};
            x_n  = 9'(sum_x >> 2);
            y_n  = 9'(sum_y >> 2);
            cv_n = 1'b1;
          end else begin
            state_n = RELEASE_PEND;
            cnt_n   = 4'd1;
          end
        end
        RELEASE_PEND: begin
          if (s1_q.hit) begin
            state_n = TOUCHING;
            cnt_n   = 4'd0;
            hx_n    = {hx_q[2:0], s1_q.ax};
            hy_n    = {hy_q[2:0], s1_q.ay};
            x_n     = 9'(sum_x >> 2);
            y_n     = 9'(sum_y >> 2);
            cv_n    = 1'b1;
          end else if (cnt_inc == RCNT) begin
            state_n = IDLE;
            cnt_n   = 4'd0;
            rp_n    = 1'b1;
            touch_n = 1'b0;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = 4'd0;
        end
      endcase
    end
  end

  // Stage 2 register: FSM, history and outputs.
  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      hx_q          <= '0;
      hy_q          <= '0;
      x             <= 9'd0;
      y             <= 9'd0;
      coord_valid   <= 1'b0;
      touching      <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state_q       <= state_n;
      cnt_q         <= cnt_n;
      hx_q          <= hx_n;
      hy_q          <= hy_n;
      x             <= x_n;
      y             <= y_n;
      coord_valid   <= cv_n;
      touching      <= touch_n;
      press_pulse   <= pp_n;
      release_pulse <= rp_n;
    end
  end

endmodule

// File: tb/tb_touch_event_filter.sv
// tb_touch_event_filter: directed checks for
// touch_event_filter.
module tb_touch_event_filter;

  logic        cclk = 1'b0;
  logic        rstb = 1'b0;
  logic        sample_valid = 1'b0;
  logic [11:0] raw_x = '0;
  logic [11:0] raw_y = '0;
  logic [11:0] raw_z = '0;
  logic [8:0]  x;
  logic [8:0]  y;
  logic        coord_valid;
  logic        touching;
  logic        press_pulse;
  logic        release_pulse;
  logic [21:0] outv;

  int tests = 0;
  int fails = 0;

  touch_event_filter dut (
    .cclk          (cclk),
    .rstb          (rstb),
    .sample_valid  (sample_valid),
    .raw_x         (raw_x),
    .raw_y         (raw_y),
    .raw_z         (raw_z),
    .x             (x),
    .y             (y),
    .coord_valid   (coord_valid),
    .touching      (touching),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse)
  );

  assign outv = {x, y, coord_valid, touching,
                 press_pulse, release_pulse};

  always #5 cclk = ~cclk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // One strobed sample; returns #1 after the edge
  // that makes its result visible.
  task automatic sample(input logic [11:0] sx,
                        input logic [11:0] sy,
                        input logic [11:0] sz);
    @(posedge cclk); #1;
    raw_x = sx;
    raw_y = sy;
    raw_z = sz;
    sample_valid = 1'b1;
    @(posedge cclk); #1;
    sample_valid = 1'b0;
    @(posedge cclk); #1;
  endtask

  initial begin
    #12;
    chk("reset_outs", 32'(outv), 32'd0);
    rstb = 1'b1;

    // two hits, async reset, two more hits
    sample(12'h490, 12'h460, 12'h200);
    sample(12'h490, 12'h460, 12'h200);
    chk("pre_rst_press", 32'(press_pulse), 32'd0);
    @(posedge cclk); #3;
    rstb = 1'b0;
    #1;
    chk("mid_rst_outs", 32'(outv), 32'd0);
    @(posedge cclk); #1;
    rstb = 1'b1;
    sample(12'h490, 12'h460, 12'h200);
    chk("rst_h1_press", 32'(press_pulse), 32'd0);
    sample(12'h490, 12'h460, 12'h200);
    chk("rst_h2_outs", 32'(outv), 32'd0);
    sample(12'h490, 12'h460, 12'h000);

    // press entry
    sample(12'h490, 12'h460, 12'h200);
    sample(12'h490, 12'h460, 12'h200);
    chk("press_h2_cv", 32'(coord_valid), 32'd0);
    sample(12'h490, 12'h460, 12'h200);
    chk("press_pp", 32'(press_pulse), 32'd1);
    chk("press_cv", 32'(coord_valid), 32'd1);
    chk("press_x", 32'(x), 32'h100);
    chk("press_y", 32'(y), 32'h100);
    chk("press_touch", 32'(touching), 32'd1);
    @(posedge cclk); #1;
    chk("press_pp_w", 32'(press_pulse), 32'd0);
    chk("press_cv_w", 32'(coord_valid), 32'd0);

    // averaging
    sample(12'h590, 12'h460, 12'h200);
    chk("avg1_x", 32'(x), 32'h110);
    chk("avg1_y", 32'(y), 32'h100);
    chk("avg1_cv", 32'(coord_valid), 32'd1);

    // single miss while touching
    sample(12'h590, 12'h460, 12'h000);
    chk("glitch_touch", 32'(touching), 32'd1);
    chk("glitch_rp", 32'(release_pulse), 32'd0);
    chk("glitch_cv", 32'(coord_valid), 32'd0);
    chk("glitch_x", 32'(x), 32'h110);
    sample(12'h590, 12'h460, 12'h200);
    chk("recov_cv", 32'(coord_valid), 32'd1);
    chk("recov_touch", 32'(touching), 32'd1);
    chk("recov_x", 32'(x), 32'h120);

    // release on boundary misses
    sample(12'h590, 12'h460, 12'h0FF);
    chk("rel1_rp", 32'(release_pulse), 32'd0);
    chk("rel1_touch", 32'(touching), 32'd1);
    sample(12'h590, 12'h460, 12'h0FF);
    chk("rel2_rp", 32'(release_pulse), 32'd1);
    chk("rel2_touch", 32'(touching), 32'd0);
    chk("rel2_x", 32'(x), 32'h120);
    chk("rel2_y", 32'(y), 32'h100);
    @(posedge cclk); #1;
    chk("rel_rp_w", 32'(release_pulse), 32'd0);

    // hit, miss, hit, hit from idle
    sample(12'h490, 12'h460, 12'h200);
    sample(12'h490, 12'h460, 12'h000);
    sample(12'h490, 12'h460, 12'h200);
    sample(12'h490, 12'h460, 12'h200);
    chk("grej_pp", 32'(press_pulse), 32'd0);
    chk("grej_touch", 32'(touching), 32'd0);
    sample(12'h490, 12'h460, 12'h000);

    // clamping
    sample(12'hFFF, 12'h000, 12'h200);
    sample(12'hFFF, 12'h000, 12'h200);
    sample(12'hFFF, 12'h000, 12'h200);
    chk("clamp_pp", 32'(press_pulse), 32'd1);
    chk("clamp_x", 32'(x), 32'h1D1);
    chk("clamp_y", 32'(y), 32'h000);
    sample(12'h050, 12'h000, 12'h200);
    chk("clampl1_x", 32'(x), 32'h15C);
    sample(12'h050, 12'h000, 12'h200);
    chk("clampl2_x", 32'(x), 32'h0E8);
    sample(12'h050, 12'h000, 12'h200);
    chk("clampl3_x", 32'(x), 32'h074);
    sample(12'h050, 12'h000, 12'h200);
    chk("clampl4_x", 32'(x), 32'h000);
    chk("clampl4_y", 32'(y), 32'h000);

    // back-to-back misses
    @(posedge cclk); #1;
    raw_z = 12'h000;
    sample_valid = 1'b1;
    @(posedge cclk); #1;
    @(posedge cclk); #1;
    sample_valid = 1'b0;
    chk("b2b_m1_rp", 32'(release_pulse), 32'd0);
    chk("b2b_m1_t", 32'(touching), 32'd1);
    @(posedge cclk); #1;
    chk("b2b_m2_rp", 32'(release_pulse), 32'd1);
    chk("b2b_m2_t", 32'(touching), 32'd0);

    // back-to-back hits
    raw_x = 12'h490;
    raw_y = 12'h460;
    raw_z = 12'h200;
    sample_valid = 1'b1;
    @(posedge cclk); #1;
    @(posedge cclk); #1;
    @(posedge cclk); #1;
    raw_x = 12'h590;
    chk("b2b_h2_pp", 32'(press_pulse), 32'd0);
    chk("b2b_h2_rp", 32'(release_pulse), 32'd0);
    @(posedge cclk); #1;
    sample_valid = 1'b0;
    chk("b2b_h3_pp", 32'(press_pulse), 32'd1);
    chk("b2b_h3_cv", 32'(coord_valid), 32'd1);
    chk("b2b_h3_x", 32'(x), 32'h100);
    @(posedge cclk); #1;
    chk("b2b_h4_pp", 32'(press_pulse), 32'd0);
    chk("b2b_h4_cv", 32'(coord_valid), 32'd1);
    chk("b2b_h4_x", 32'(x), 32'h110);
    chk("b2b_h4_y", 32'(y), 32'h100);
    @(posedge cclk); #1;
    chk("b2b_idle_cv", 32'(coord_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
